// File: rtl/csr_file_pkg.sv
// Shared CSR constants: addresses, mstatus bit positions, write masks and
// address-decode helpers for the machine-mode CSR file.
package csr_file_pkg;

  localparam int unsigned CSR_ADDR_W = 12;
  localparam int unsigned CSR_DATA_W = 32;

  typedef logic [CSR_ADDR_W-1:0] csr_addr_t;
  typedef logic [CSR_DATA_W-1:0] csr_data_t;

  // CSR addresses
  localparam csr_addr_t CSR_ZERO_ADDR  = 12'h000;
  localparam csr_addr_t CSR_MSTATUS    = 12'h300;
  localparam csr_addr_t CSR_MISA       = 12'h301;
  localparam csr_addr_t CSR_MIE        = 12'h304;
  localparam csr_addr_t CSR_MTVEC      = 12'h305;
  localparam csr_addr_t CSR_MSCRATCH   = 12'h340;
  localparam csr_addr_t CSR_MEPC       = 12'h341;
  localparam csr_addr_t CSR_MCAUSE     = 12'h342;
  localparam csr_addr_t CSR_MTVAL      = 12'h343;
  localparam csr_addr_t CSR_MCYCLE     = 12'hB00;
  localparam csr_addr_t CSR_MINSTRET   = 12'hB02;
  localparam csr_addr_t CSR_MCYCLEH    = 12'hB80;
  localparam csr_addr_t CSR_MINSTRETH  = 12'hB82;
  localparam csr_addr_t CSR_CYCLE      = 12'hC00;
  localparam csr_addr_t CSR_INSTRET    = 12'hC02;
  localparam csr_addr_t CSR_CYCLEH     = 12'hC80;
  localparam csr_addr_t CSR_INSTRETH   = 12'hC82;

  // mstatus bit positions
  localparam int unsigned MSTATUS_MIE_BIT  = 3;
  localparam int unsigned MSTATUS_MPIE_BIT = 7;

  // Per-CSR writable masks and fixed read-as-one bits
  localparam csr_data_t MSTATUS_WMASK  = 32'h0000_0088;
  localparam csr_data_t MSTATUS_RO_VAL = 32'h0000_1800;
  localparam csr_data_t MIE_WMASK      = 32'h0000_0888;
  localparam csr_data_t MTVEC_WMASK    = 32'hFFFF_FFFC;
  localparam csr_data_t MEPC_WMASK     = 32'hFFFF_FFFC;
  localparam csr_data_t FULL_WMASK     = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    CSR_ACC_NONE = 2'd0,
    CSR_ACC_RO   = 2'd1,
    CSR_ACC_RW   = 2'd2
  } csr_access_e;

  // Classify an address as unimplemented, read-only or read/write
  function automatic csr_access_e csr_access(input csr_addr_t addr);
    csr_access_e acc;
    acc = CSR_ACC_NONE;
    case (addr)
      CSR_MSTATUS, CSR_MIE, CSR_MTVEC, CSR_MSCRATCH,
      CSR_MEPC, CSR_MCAUSE, CSR_MTVAL,
      CSR_MCYCLE, CSR_MCYCLEH, CSR_MINSTRET, CSR_MINSTRETH: acc = CSR_ACC_RW;
      CSR_MISA, CSR_CYCLE, CSR_CYCLEH,
      CSR_INSTRET, CSR_INSTRETH:                            acc = CSR_ACC_RO;
      CSR_ZERO_ADDR:                                        acc = CSR_ACC_NONE;
      default:                                              acc = CSR_ACC_NONE;
    endcase
    return acc;
  endfunction

  // Bits of the write data that land in storage for a given address
  function automatic csr_data_t csr_wmask(input csr_addr_t addr);
    csr_data_t m;
    case (addr)
      CSR_MSTATUS: m = MSTATUS_WMASK;
      CSR_MIE:     m = MIE_WMASK;
      CSR_MTVEC:   m = MTVEC_WMASK;
      CSR_MEPC:    m = MEPC_WMASK;
      default:     m = FULL_WMASK;
    endcase
    return m;
  endfunction

  // Constant bits a CSR always reads back regardless of the write data
  function automatic csr_data_t csr_wfixed(input csr_addr_t addr);
    return (addr == CSR_MSTATUS) ? MSTATUS_RO_VAL : '0;
  endfunction

endpackage

// File: rtl/csr_file_counter64.sv
// 64-bit counter with increment enable, per-half write and carry suppression
// when the high half is written.
module csr_counter64 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        inc,
  input  logic        wr_lo,
  input  logic        wr_hi,
  input  logic [31:0] wdata,
  output logic [63:0] count
);

  localparam int unsigned HALF_W = 32;

  logic [HALF_W-1:0] lo_q;
  logic [HALF_W-1:0] hi_q;
  logic [HALF_W-1:0] lo_inc;
  logic              carry;

  assign {carry, lo_inc} = {1'b0, lo_q} + (HALF_W+1)'(inc);
  assign count = {hi_q, lo_q};

  // Low-half write freezes the count; high-half write drops the carry
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lo_q <= '0;
      hi_q <= '0;
    end else if (wr_lo) begin
      lo_q <= wdata;
    end else if (wr_hi) begin
      hi_q <= wdata;
      lo_q <= lo_inc;
    end else begin
      lo_q <= lo_inc;
      hi_q <= hi_q + HALF_W'(carry);
    end
  end

endmodule

// File: rtl/csr_file.sv
// Machine-mode CSR storage: write port from MEM/WB, combinational read port
// to execute, cycle/instret counters and trap/mret state updates.
module csr_file
  import csr_file_pkg::*;
#(
  parameter int unsigned       DATA_W   = 32,
  parameter int unsigned       ADDR_W   = 12,
  parameter logic [DATA_W-1:0] MISA_VAL = 32'h4000_0100
) (
  input  logic              clk_in,
  input  logic              reset_n_in,
  input  logic              csr_we_in,
  input  logic [ADDR_W-1:0] csr_waddr_in,
  input  logic [DATA_W-1:0] csr_wdata_in,
  input  logic              instret_incr_in,
  input  logic [ADDR_W-1:0] csr_raddr_in,
  output logic [DATA_W-1:0] csr_rdata_out,
  output logic              csr_rillegal_out,
  output logic              csr_willegal_out,
  input  logic              trap_in,
  input  logic [DATA_W-1:0] trap_epc_in,
  input  logic [DATA_W-1:0] trap_cause_in,
  input  logic [DATA_W-1:0] trap_tval_in,
  input  logic              mret_in,
  output logic [DATA_W-1:0] mtvec_out,
  output logic [DATA_W-1:0] mepc_out,
  output logic              mie_global_out
);

  csr_addr_t   waddr;
  csr_addr_t   raddr;
  csr_data_t   wdata;
  csr_data_t   wdata_m;
  csr_access_e waccess;
  logic        we_ok;

  logic mstatus_mie_q;
  logic mstatus_mpie_q;
  csr_data_t mie_q;
  csr_data_t mtvec_q;
  csr_data_t mscratch_q;
  csr_data_t mepc_q;
  csr_data_t mcause_q;
  csr_data_t mtval_q;
  logic      willegal_q;

  logic [63:0] mcycle;
  logic [63:0] minstret;

  csr_data_t rdata;
  logic      rillegal;

  assign waddr   = CSR_ADDR_W'(csr_waddr_in);
  assign raddr   = CSR_ADDR_W'(csr_raddr_in);
  assign wdata   = CSR_DATA_W'(csr_wdata_in);
  assign waccess = csr_access(waddr);
  assign we_ok   = csr_we_in && (waccess == CSR_ACC_RW);
  assign wdata_m = (wdata & csr_wmask(waddr)) | csr_wfixed(waddr);

  logic wr_mstatus, wr_mie, wr_mtvec, wr_mscratch, wr_mepc, wr_mcause, wr_mtval;
  assign wr_mstatus  = we_ok && (waddr == CSR_MSTATUS);
  assign wr_mie      = we_ok && (waddr == CSR_MIE);
  assign wr_mtvec    = we_ok && (waddr == CSR_MTVEC);
  assign wr_mscratch = we_ok && (waddr == CSR_MSCRATCH);
  assign wr_mepc     = we_ok && (waddr == CSR_MEPC);
  assign wr_mcause   = we_ok && (waddr == CSR_MCAUSE);
  assign wr_mtval    = we_ok && (waddr == CSR_MTVAL);

  csr_counter64 u_mcycle (
    .clk   (clk_in),
    .rst_n (reset_n_in),
    .inc   (1'b1),
    .wr_lo (we_ok && (waddr == CSR_MCYCLE)),
    .wr_hi (we_ok && (waddr == CSR_MCYCLEH)),
    .wdata (wdata),
    .count (mcycle)
  );

  csr_counter64 u_minstret (
    .clk   (clk_in),
    .rst_n (reset_n_in),
    .inc   (instret_incr_in),
    .wr_lo (we_ok && (waddr == CSR_MINSTRET)),
    .wr_hi (we_ok && (waddr == CSR_MINSTRETH)),
    .wdata (wdata),
    .count (minstret)
  );

  // CSR storage; trap owns mstatus/mepc/mcause/mtval, then mret, then writes
  always_ff @(posedge clk_in) begin
    if (!reset_n_in) begin
      mstatus_mie_q  <= 1'b0;
      mstatus_mpie_q <= 1'b0;
      mie_q          <= '0;
      mtvec_q        <= '0;
      mscratch_q     <= '0;
      mepc_q         <= '0;
      mcause_q       <= '0;
      mtval_q        <= '0;
      willegal_q     <= 1'b0;
    end else begin
      willegal_q <= csr_we_in && (waccess != CSR_ACC_RW);
      if (wr_mie)      mie_q      <= wdata_m;
      if (wr_mtvec)    mtvec_q    <= wdata_m;
      if (wr_mscratch) mscratch_q <= wdata_m;
      if (trap_in) begin
        mepc_q         <= CSR_DATA_W'(trap_epc_in) & MEPC_WMASK;
        mcause_q       <= CSR_DATA_W'(trap_cause_in);
        mtval_q        <= CSR_DATA_W'(trap_tval_in);
        mstatus_mpie_q <= mstatus_mie_q;
        mstatus_mie_q  <= 1'b0;
      end else begin
        if (wr_mepc)   mepc_q   <= wdata_m;
        if (wr_mcause) mcause_q <= wdata_m;
        if (wr_mtval)  mtval_q  <= wdata_m;
        if (mret_in) begin
          mstatus_mie_q  <= mstatus_mpie_q;
          mstatus_mpie_q <= 1'b1;
        end else if (wr_mstatus) begin
          mstatus_mie_q  <= wdata_m[MSTATUS_MIE_BIT];
          mstatus_mpie_q <= wdata_m[MSTATUS_MPIE_BIT];
        end
      end
    end
  end

  // Read mux with same-cycle write bypass for writable addresses
  always_comb begin
    rdata    = '0;
    rillegal = 1'b0;
    case (raddr)
      CSR_MSTATUS: begin
        rdata                   = MSTATUS_RO_VAL;
        rdata[MSTATUS_MIE_BIT]  = mstatus_mie_q;
        rdata[MSTATUS_MPIE_BIT] = mstatus_mpie_q;
      end
      CSR_MISA:                   rdata = CSR_DATA_W'(MISA_VAL);
      CSR_MIE:                    rdata = mie_q;
      CSR_MTVEC:                  rdata = mtvec_q;
      CSR_MSCRATCH:               rdata = mscratch_q;
      CSR_MEPC:                   rdata = mepc_q;
      CSR_MCAUSE:                 rdata = mcause_q;
      CSR_MTVAL:                  rdata = mtval_q;
      CSR_MCYCLE,   CSR_CYCLE:    rdata = mcycle[31:0];
      CSR_MCYCLEH,  CSR_CYCLEH:   rdata = mcycle[63:32];
      CSR_MINSTRET, CSR_INSTRET:  rdata = minstret[31:0];
      CSR_MINSTRETH, CSR_INSTRETH: rdata = minstret[63:32];
      default:                    rillegal = 1'b1;
    endcase
    if (we_ok && (waddr == raddr)) begin
      rdata = wdata_m;
    end
  end

  assign csr_rdata_out    = DATA_W'(rdata);
  assign csr_rillegal_out = rillegal;
  assign csr_willegal_out = willegal_q;
  assign mtvec_out        = DATA_W'(mtvec_q);
  assign mepc_out         = DATA_W'(mepc_q);
  assign mie_global_out   = mstatus_mie_q;

endmodule

// File: tb/tb_csr_file.sv
// Self-checking bench for csr_file: directed scenarios plus a randomized run
// against an architectural model of the CSR state.
module tb_csr_file;

  logic        clk = 1'b0;
  logic        rst_n, we, incr, trap, mret;
  logic [11:0] waddr, raddr;
  logic [31:0] wdata, epc, cause, tval;
  logic [31:0] rdata, mtvec_o, mepc_o;
  logic        rillegal, willegal, mie_g;

  int tests_run = 0;
  int tests_failed = 0;

  // Architectural model state
  logic [63:0] m_cycle, m_instret;
  logic [31:0] m_mie_reg, m_mtvec, m_mscratch, m_mepc, m_mcause, m_mtval;
  logic        m_mie, m_mpie, m_willegal;

  logic [11:0] addr_pool [18] = '{12'h300, 12'h301, 12'h304, 12'h305, 12'h340,
    12'h341, 12'h342, 12'h343, 12'hB00, 12'hB80, 12'hB02, 12'hB82, 12'hC00,
    12'hC80, 12'hC02, 12'hC82, 12'h000, 12'h7C0};

  always #5 clk = ~clk;

  csr_file #(.DATA_W(32), .ADDR_W(12), .MISA_VAL(32'h4000_0100)) u_dut (
    .clk_in(clk), .reset_n_in(rst_n), .csr_we_in(we), .csr_waddr_in(waddr),
    .csr_wdata_in(wdata), .instret_incr_in(incr), .csr_raddr_in(raddr),
    .csr_rdata_out(rdata), .csr_rillegal_out(rillegal),
    .csr_willegal_out(willegal), .trap_in(trap), .trap_epc_in(epc),
    .trap_cause_in(cause), .trap_tval_in(tval), .mret_in(mret),
    .mtvec_out(mtvec_o), .mepc_out(mepc_o), .mie_global_out(mie_g)
  );

  function automatic bit is_writable(input logic [11:0] a);
    return a inside {12'h300, 12'h304, 12'h305, 12'h340, 12'h341, 12'h342,
                     12'h343, 12'hB00, 12'hB80, 12'hB02, 12'hB82};
  endfunction

  function automatic bit is_readonly(input logic [11:0] a);
    return a inside {12'h301, 12'hC00, 12'hC80, 12'hC02, 12'hC82};
  endfunction

  function automatic logic [31:0] masked_write(input logic [11:0] a, input logic [31:0] d);
    case (a)
      12'h300:          return (d & 32'h88) | 32'h1800;
      12'h304:          return d & 32'h888;
      12'h305, 12'h341: return d & ~32'h3;
      default:          return d;
    endcase
  endfunction

  function automatic logic [31:0] model_stored(input logic [11:0] a);
    case (a)
      12'h300:          return 32'h1800 | {24'h0, m_mpie, 3'b000, m_mie, 3'b000};
      12'h301:          return 32'h4000_0100;
      12'h304:          return m_mie_reg;
      12'h305:          return m_mtvec;
      12'h340:          return m_mscratch;
      12'h341:          return m_mepc;
      12'h342:          return m_mcause;
      12'h343:          return m_mtval;
      12'hB00, 12'hC00: return m_cycle[31:0];
      12'hB80, 12'hC80: return m_cycle[63:32];
      12'hB02, 12'hC02: return m_instret[31:0];
      12'hB82, 12'hC82: return m_instret[63:32];
      default:          return 32'h0;
    endcase
  endfunction

  function automatic logic [31:0] model_read(input logic [11:0] a);
    if (we && waddr == a && is_writable(a)) return masked_write(a, wdata);
    return model_stored(a);
  endfunction

  // Advance the model by one clock edge using the currently driven inputs
  function automatic void model_update();
    logic [63:0] nc, ni;
    if (!rst_n) begin
      m_cycle = 0; m_instret = 0; m_mie_reg = 0; m_mtvec = 0; m_mscratch = 0;
      m_mepc = 0; m_mcause = 0; m_mtval = 0; m_mie = 0; m_mpie = 0; m_willegal = 0;
      return;
    end
    nc = m_cycle + 64'd1;
    if (we && waddr == 12'hB00)      nc = {m_cycle[63:32], wdata};
    else if (we && waddr == 12'hB80) nc = {wdata, m_cycle[31:0] + 32'd1};
    ni = m_instret + 64'(incr);
    if (we && waddr == 12'hB02)      ni = {m_instret[63:32], wdata};
    else if (we && waddr == 12'hB82) ni = {wdata, m_instret[31:0] + 32'(incr)};
    m_willegal = we && !is_writable(waddr);
    if (we && waddr == 12'h304) m_mie_reg  = wdata & 32'h888;
    if (we && waddr == 12'h305) m_mtvec    = wdata & ~32'h3;
    if (we && waddr == 12'h340) m_mscratch = wdata;
    if (trap) begin
      m_mepc = epc & ~32'h3; m_mcause = cause; m_mtval = tval;
      m_mpie = m_mie; m_mie = 1'b0;
    end else begin
      if (we && waddr == 12'h341) m_mepc   = wdata & ~32'h3;
      if (we && waddr == 12'h342) m_mcause = wdata;
      if (we && waddr == 12'h343) m_mtval  = wdata;
      if (mret) begin
        m_mie = m_mpie; m_mpie = 1'b1;
      end else if (we && waddr == 12'h300) begin
        m_mie = wdata[3]; m_mpie = wdata[7];
      end
    end
    m_cycle = nc; m_instret = ni;
  endfunction

  task automatic tick();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic idle();
    we = 0; trap = 0; mret = 0; incr = 0;
  endtask

  task automatic test_reset();
    rst_n = 0; we = 1; waddr = 12'h305; wdata = $urandom; incr = 1;
    trap = 1; mret = 1; epc = $urandom; cause = $urandom; tval = $urandom; raddr = 12'h300;
    repeat (3) tick();
    tests_run++; if (mtvec_o !== 32'h0) begin tests_failed++; $display("FAIL reset_mtvec: got %h expected 00000000", mtvec_o); end
    tests_run++; if (mepc_o !== 32'h0) begin tests_failed++; $display("FAIL reset_mepc: got %h expected 00000000", mepc_o); end
    tests_run++; if ({mie_g, willegal} !== 2'b00) begin tests_failed++; $display("FAIL reset_flags: got mie=%b willegal=%b expected 0 0", mie_g, willegal); end
    rst_n = 1; idle(); raddr = 12'hB00;
    for (int i = 0; i < 3; i++) begin
      #1;
      tests_run++; if (rdata !== 32'(i)) begin tests_failed++; $display("FAIL reset_mcycle_%0d: got %h expected %h", i, rdata, 32'(i)); end
      tick();
    end
    raddr = 12'h300; #1;
    tests_run++; if (rdata !== 32'h1800) begin tests_failed++; $display("FAIL reset_mstatus: got %h expected 00001800", rdata); end
  endtask

  task automatic test_mtvec_bypass();
    we = 1; waddr = 12'h305; wdata = 32'h8000_0103; raddr = 12'h305; #1;
    tests_run++; if (rdata !== 32'h8000_0100) begin tests_failed++; $display("FAIL mtvec_bypass: got %h expected 80000100", rdata); end
    tick(); idle(); #1;
    tests_run++; if (mtvec_o !== 32'h8000_0100) begin tests_failed++; $display("FAIL mtvec_out: got %h expected 80000100", mtvec_o); end
    tests_run++; if (rdata !== 32'h8000_0100) begin tests_failed++; $display("FAIL mtvec_read: got %h expected 80000100", rdata); end
  endtask

  task automatic test_counter_wrap();
    we = 1; waddr = 12'hB00; wdata = 32'hFFFF_FFFE; tick();
    waddr = 12'hB80; wdata = 32'h0; raddr = 12'hB80; #1;
    tests_run++; if (rdata !== 32'h0) begin tests_failed++; $display("FAIL mcycleh_bypass: got %h expected 00000000", rdata); end
    tick(); idle(); tick(); tick();
    raddr = 12'hB80; #1;
    tests_run++; if (rdata !== 32'h1) begin tests_failed++; $display("FAIL mcycleh_carry: got %h expected 00000001", rdata); end
    raddr = 12'hB00; #1;
    tests_run++; if (rdata !== 32'h1) begin tests_failed++; $display("FAIL mcycle_after_wrap: got %h expected 00000001", rdata); end
    we = 1; waddr = 12'hC00; wdata = 32'h5; raddr = 12'hC00; #1;
    tests_run++; if (rillegal !== 1'b0) begin tests_failed++; $display("FAIL cycle_rillegal: got %b expected 0", rillegal); end
    tick(); idle(); raddr = 12'hB00; #1;
    tests_run++; if (willegal !== 1'b1) begin tests_failed++; $display("FAIL ro_willegal: got %b expected 1", willegal); end
    tests_run++; if (rdata !== 32'h2) begin tests_failed++; $display("FAIL ro_write_ignored: got %h expected 00000002", rdata); end
    tick();
    tests_run++; if (willegal !== 1'b0) begin tests_failed++; $display("FAIL willegal_clear: got %b expected 0", willegal); end
    we = 1; waddr = 12'h7C0; wdata = $urandom; raddr = 12'h7C0; #1;
    tests_run++; if ({rillegal, rdata} !== {1'b1, 32'h0}) begin tests_failed++; $display("FAIL unimpl_read: got ill=%b data=%h expected 1 00000000", rillegal, rdata); end
    tick(); idle();
    tests_run++; if (willegal !== 1'b1) begin tests_failed++; $display("FAIL unimpl_willegal: got %b expected 1", willegal); end
  endtask

  task automatic test_trap_mret();
    we = 1; waddr = 12'h300; wdata = 32'h8; tick(); idle();
    tests_run++; if (mie_g !== 1'b1) begin tests_failed++; $display("FAIL mie_set: got %b expected 1", mie_g); end
    trap = 1; epc = 32'h1236; cause = 32'hB; tval = 32'h0; tick(); idle();
    tests_run++; if (mepc_o !== 32'h1234) begin tests_failed++; $display("FAIL trap_mepc: got %h expected 00001234", mepc_o); end
    tests_run++; if (mie_g !== 1'b0) begin tests_failed++; $display("FAIL trap_mie: got %b expected 0", mie_g); end
    raddr = 12'h342; #1;
    tests_run++; if (rdata !== 32'hB) begin tests_failed++; $display("FAIL trap_mcause: got %h expected 0000000b", rdata); end
    raddr = 12'h300; #1;
    tests_run++; if (rdata !== 32'h1880) begin tests_failed++; $display("FAIL trap_mstatus: got %h expected 00001880", rdata); end
    mret = 1; tick(); idle();
    tests_run++; if (mie_g !== 1'b1) begin tests_failed++; $display("FAIL mret_mie: got %b expected 1", mie_g); end
    tests_run++; if (rdata !== 32'h1888) begin tests_failed++; $display("FAIL mret_mstatus: got %h expected 00001888", rdata); end
  endtask

  task automatic test_trap_collision();
    trap = 1; epc = 32'h4000_0002; we = 1; waddr = 12'h341; wdata = 32'hDEAD_BEEC; tick(); idle();
    tests_run++; if (mepc_o !== 32'h4000_0000) begin tests_failed++; $display("FAIL trap_over_mepc_write: got %h expected 40000000", mepc_o); end
    trap = 1; epc = 32'h100; we = 1; waddr = 12'h340; wdata = 32'h1234_5678; tick(); idle();
    raddr = 12'h340; #1;
    tests_run++; if (rdata !== 32'h1234_5678) begin tests_failed++; $display("FAIL trap_mscratch_write: got %h expected 12345678", rdata); end
    tests_run++; if (mepc_o !== 32'h100) begin tests_failed++; $display("FAIL trap2_mepc: got %h expected 00000100", mepc_o); end
    mret = 1; we = 1; waddr = 12'h300; wdata = 32'h88; tick(); idle();
    raddr = 12'h300; #1;
    tests_run++; if (rdata !== 32'h1880) begin tests_failed++; $display("FAIL mret_drops_write: got %h expected 00001880", rdata); end
  endtask

  task automatic test_instret_reset();
    rst_n = 0; tick(); rst_n = 1; idle();
    for (int i = 0; i < 5; i++) begin
      incr = 1; tick(); incr = 0; tick();
    end
    raddr = 12'hB02; #1;
    tests_run++; if (rdata !== 32'd5) begin tests_failed++; $display("FAIL minstret_count: got %h expected 00000005", rdata); end
    raddr = 12'hB82; #1;
    tests_run++; if (rdata !== 32'd0) begin tests_failed++; $display("FAIL minstreth_count: got %h expected 00000000", rdata); end
    incr = 1; tick(); tick();
    rst_n = 0; tick(); rst_n = 1; idle();
    for (int i = 0; i < 4; i++) begin
      raddr = addr_pool[8 + i]; #1;
      tests_run++; if (rdata !== 32'h0) begin tests_failed++; $display("FAIL counter_reset_%h: got %h expected 00000000", raddr, rdata); end
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      rst_n = ($urandom_range(0, 99) != 0);
      we    = $urandom_range(0, 1);
      waddr = ($urandom_range(0, 7) == 0) ? 12'($urandom) : addr_pool[$urandom_range(0, 17)];
      wdata = $urandom;
      raddr = ($urandom_range(0, 2) == 0) ? waddr : addr_pool[$urandom_range(0, 17)];
      incr  = $urandom_range(0, 1);
      trap  = ($urandom_range(0, 9) == 0);
      mret  = ($urandom_range(0, 9) == 0);
      epc = $urandom; cause = $urandom; tval = $urandom;
      #1;
      tests_run++; if (rdata !== model_read(raddr)) begin tests_failed++; $display("FAIL rand_rdata[%0d] addr %h: got %h expected %h", n, raddr, rdata, model_read(raddr)); end
      tests_run++; if (rillegal !== !(is_writable(raddr) || is_readonly(raddr))) begin tests_failed++; $display("FAIL rand_rillegal[%0d] addr %h: got %b", n, raddr, rillegal); end
      tick();
      tests_run++; if ({mtvec_o, mepc_o, mie_g, willegal} !== {m_mtvec, m_mepc, m_mie, m_willegal}) begin
        tests_failed++;
        $display("FAIL rand_state[%0d]: got mtvec=%h mepc=%h mie=%b wil=%b expected %h %h %b %b", n,
                 mtvec_o, mepc_o, mie_g, willegal, m_mtvec, m_mepc, m_mie, m_willegal);
      end
    end
    idle();
  endtask

  initial begin
    test_reset();
    test_mtvec_bypass();
    test_counter_wrap();
    test_trap_mret();
    test_trap_collision();
    test_instret_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
